// File: rtl/clockworks.sv
// Root clock/reset generator: divides the board clock by 2^(SLOW+1) (or passes it
// through when SLOW=0) and produces a stretched active-low reset released on clk.
module clockworks #(
  parameter int SLOW         = 0,
  parameter int RESET_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESET,
  output logic clk,
  output logic resetn
);

  // Power-up starts in reset: the synchronizer flops come up set.
  logic r_rs1 = 1'b1;
  logic r_rs0 = 1'b1;
  logic w_rst_int;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rs1 <= 1'b1;
      r_rs0 <= 1'b1;
    end else begin
      r_rs1 <= 1'b0;
      r_rs0 <= r_rs1;
    end
  end

  assign w_rst_int = r_rs0;

  generate
    if (SLOW == 0) begin : g_bypass
      assign clk = CLK;
    end else begin : g_div
      localparam logic [SLOW:0] CNT_ONE = 1;
      logic [SLOW:0] r_cnt = '0;

      always_ff @(posedge CLK or posedge w_rst_int) begin
        if (w_rst_int) r_cnt <= '0;
        else           r_cnt <= r_cnt + CNT_ONE;
      end

      // MSB straight from a flop: glitch-free, 50% duty.
      assign clk = r_cnt[SLOW];
    end
  endgenerate

  localparam logic [RESET_CYCLES-1:0] SH_ONE = 1;
  logic [RESET_CYCLES-1:0] r_shift = '0;

  always_ff @(posedge clk or posedge w_rst_int) begin
    if (w_rst_int) r_shift <= '0;
    else           r_shift <= (r_shift << 1) | SH_ONE;
  end

  assign resetn = r_shift[RESET_CYCLES-1];

endmodule

// File: tb/tb_clockworks.sv
// Directed bench: three clockworks configurations on one board clock, checked
// edge-by-edge against hand-derived release timing.
module tb_clockworks;

  localparam int BIG = 1 << 20;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET2 = 1'b0, RESET0 = 1'b0, RESET3 = 1'b0;
  logic clk2, rstn2, clk0, rstn0, clk3, rstn3;

  clockworks #(.SLOW(2), .RESET_CYCLES(4)) u_s2 (
    .CLK(CLK), .RESET(RESET2), .clk(clk2), .resetn(rstn2));
  clockworks #(.SLOW(0), .RESET_CYCLES(4)) u_s0 (
    .CLK(CLK), .RESET(RESET0), .clk(clk0), .resetn(rstn0));
  clockworks #(.SLOW(3), .RESET_CYCLES(2)) u_s3 (
    .CLK(CLK), .RESET(RESET3), .clk(clk3), .resetn(rstn3));

  int n_assert = 0;
  int n_fail   = 0;
  int n        = 0;   // CLK rising edges seen since time 0
  int e2_2, e2_0, e2_3;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, got, exp, n);
    end
  endtask

  // clk rises at E2+2^s and every 2^(s+1) edges after; low before E2.
  function automatic logic exp_clk(input int s, input int e2);
    if (n < e2) return 1'b0;
    return 1'(((n - e2) >> s) & 1);
  endfunction

  function automatic logic exp_rstn(input int s, input int rc, input int e2);
    int er;
    if (s == 0) er = e2 + rc;
    else        er = e2 + (1 << s) + (rc - 1) * (1 << (s + 1));
    return (n >= er);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    n++;
  endtask

  task automatic check_all();
    chk("s2_clk",    clk2,  exp_clk(2, e2_2));
    chk("s2_resetn", rstn2, exp_rstn(2, 4, e2_2));
    chk("s0_clk",    clk0,  1'b1);
    chk("s0_resetn", rstn0, exp_rstn(0, 4, e2_0));
    chk("s3_clk",    clk3,  exp_clk(3, e2_3));
    chk("s3_resetn", rstn3, exp_rstn(3, 2, e2_3));
  endtask

  initial begin
    // Power-up with no RESET pulse: E2 is edge 2 for every instance.
    e2_2 = 2; e2_0 = 2; e2_3 = 2;
    #1;
    chk("pwr_s2_clk",    clk2,  1'b0);
    chk("pwr_s2_resetn", rstn2, 1'b0);
    chk("pwr_s0_clk",    clk0,  1'b0);
    chk("pwr_s0_resetn", rstn0, 1'b0);
    chk("pwr_s3_clk",    clk3,  1'b0);
    chk("pwr_s3_resetn", rstn3, 1'b0);
    repeat (40) begin tick(); check_all(); end

    // 3 ns RESET glitch between edges 40 and 41 while clk2 is high.
    chk("pre_glitch_s2_clk", clk2, 1'b1);
    #1;
    RESET2 = 1'b1; RESET0 = 1'b1;
    e2_2 = BIG; e2_0 = BIG;
    #1;
    chk("glitch_s2_resetn", rstn2, 1'b0);
    chk("glitch_s2_clk",    clk2,  1'b0);
    chk("glitch_s0_resetn", rstn0, 1'b0);
    chk("glitch_s0_clk_hi", clk0,  1'b1);
    #2;
    RESET2 = 1'b0; RESET0 = 1'b0;
    e2_2 = 42; e2_0 = 42;
    #1;
    chk("glitch_s0_clk_lo", clk0,  1'b0);
    chk("glitch_s2_clk_lo", clk2,  1'b0);
    chk("glitch_s2_hold",   rstn2, 1'b0);
    repeat (40) begin tick(); check_all(); end

    // Reset SLOW=3 instance while its clk is high.
    chk("pre_mid_s3_clk",    clk3,  1'b1);
    chk("pre_mid_s3_resetn", rstn3, 1'b1);
    #1;
    RESET3 = 1'b1;
    e2_3 = BIG;
    #1;
    chk("mid_s3_clk",    clk3,  1'b0);
    chk("mid_s3_resetn", rstn3, 1'b0);
    repeat (3) begin tick(); check_all(); end
    RESET3 = 1'b0;
    e2_3 = 85;
    repeat (37) begin tick(); check_all(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/clockworks.md
# clockworks

Clock and reset generator at the root of the SoC. Divides the board clock `CLK` down to a slow design clock `clk` by a power of two, so LED-level activity is visible. It also turns the asynchronous board `RESET` into a clean, stretched, active-low `resetn` that deasserts synchronously to `clk`. Every register in the design runs on `clk` and is reset by `resetn`.

## Interface
- `SLOW`, default 0: division exponent.
  - `SLOW`=0 bypasses the divider: `clk` = `CLK`.
  - `SLOW`≥1: `clk` period is 2^(`SLOW`+1) `CLK` cycles.
- `RESET_CYCLES`, default 4 (legal ≥1): number of `clk` rising edges `resetn` is held low after the internal reset releases.
- `CLK` in 1: board clock. This is the block's only clock.
- `RESET` in 1: asynchronous, active-high reset.
- `clk` out 1: divided design clock.
- `resetn` out 1: active-low design reset, synchronous to `clk`.

## Operation
- **Reset synchronizer, `CLK` domain.** Two flops, `rs1` and `rs0`.
  - `RESET` high sets both flops asynchronously.
  - Otherwise each flop shifts in 0 on every `CLK` rising edge.
  - `rst_int` = `rs0`.
  - `rst_int` asserts asynchronously and deasserts on the 2nd `CLK` rising edge after `RESET` goes low. Call that edge E2.
  - A `RESET` pulse shorter than one `CLK` period must still cause a full reset.
- **Divider, used when `SLOW`≥1.**
  - Counter `cnt` is `SLOW`+1 bits wide and is asynchronously cleared to 0 while `rst_int` is high.
  - Otherwise `cnt` increments by 1 on each `CLK` rising edge and wraps from all-ones to 0.
  - `clk` = `cnt[SLOW]`, taken straight from a flop with no combinational logic, so it is glitch-free with a 50% duty cycle.
- **Bypass, `SLOW`=0.** `clk` = `CLK` by direct wire. No counter is instantiated.
- **Reset stretcher, `clk` domain.**
  - Shift register of `RESET_CYCLES` flops, asynchronously cleared while `rst_int` is high.
  - Otherwise it shifts in 1 on each `clk` rising edge.
  - `resetn` = last stage.
- **Reset mid-operation.** `RESET` rising at any time immediately forces `resetn`=0 and clears `cnt`, so `clk`=0 when `SLOW`≥1. The full release sequence then repeats.
- **No X propagation.** Before the first `RESET`, all flops have initial value 0 in simulation and FPGA, except `rs1` and `rs0`, which initialise to 1. Power-up therefore behaves as a reset.

## Timing
- **While `RESET` is high:**
  - `resetn` = 0.
  - `clk` = 0 when `SLOW`≥1, and `CLK` when `SLOW`=0.
  - `cnt` = 0.
- **`SLOW`≥1:**
  - The first `clk` rising edge is at `CLK` edge E2+2^`SLOW`.
  - Subsequent `clk` rising edges follow every 2^(`SLOW`+1) `CLK` edges.
  - `clk` falls at `cnt` wrap.
  - `resetn` rises at `CLK` edge E2 + 2^`SLOW` + (`RESET_CYCLES`−1)·2^(`SLOW`+1), coincident with the `RESET_CYCLES`-th `clk` rising edge.
- **`SLOW`=0:** `resetn` rises at `CLK` edge E2+`RESET_CYCLES`. The shift register does not capture at E2 itself.
- **`clk`-domain consumers:** they first see `resetn`=1 at the `clk` rising edge after it rises. Deassertion never coincides with a `clk` edge seen by consumers as ambiguous.
- **`RESET` assertion:** takes effect on `resetn` with zero clock latency (combinational path through async clears only).

## Test plan
- **Divider period.** `SLOW`=2, `RESET_CYCLES`=4. Release `RESET` → `rst_int` falls at E2. `clk` rises at E2+4, E2+12, E2+20, and so on, and is high for 4 `CLK` cycles out of every 8.
- **Stretched release.** Same config → `resetn` stays 0 until `CLK` edge E2+28, then stays 1 indefinitely while `RESET`=0.
- **Bypass.** `SLOW`=0, `RESET_CYCLES`=4 → `clk` toggles identically to `CLK` during and after reset. `resetn` rises at E2+4.
- **Short pulse.** After `resetn`=1, drive a 0.3-`CLK`-period `RESET` glitch between edges → `resetn` goes 0 immediately and `clk` goes 0. The release sequence repeats with `resetn` rising at the new E2+28.
- **Reset mid-count.** `SLOW`=3. Assert `RESET` while `clk`=1 → `clk` drops to 0 asynchronously. After release, the first `clk` rise is at E2+8.
- **Power-up.** No `RESET` pulse at all → `resetn`=0 initially. It rises at `CLK` edge 2 + 2^`SLOW` + (`RESET_CYCLES`−1)·2^(`SLOW`+1), counting edges from time 0.
